frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Frame-level controller for the 160x120 colour-RAM framebuffer. On each frame tick it walks the pixel grid in up to three passes: clear to background, render (write the scene colour for every pixel), scan out (read RAM and drive the VGA write port). It sits between the 60 Hz rate divider, the combinational scene-colour logic, the colour RAM and the VGA adapter, and is the sole owner of the RAM address/write port.

## Interface
- H_PIXELS, 160, pixels per row (x range 0..H_PIXELS-1, at most 256)
- V_PIXELS, 120, rows (y range 0..V_PIXELS-1, at most 128)
- BG_COLOUR, 3'd7, colour written during the clear pass
- RAM_LATENCY, 1, colour-RAM read latency in cycles (1..3)

Ports:
- iClock  in  1  system clock; all state changes on its rising edge
- iResetn  in  1  asynchronous, active-low reset
- iFrameTick  in  1  one-cycle frame-rate pulse from the rate divider
- iColour  in  3  scene colour for the pixel currently on oAddr (combinational, same cycle)
- iRamQ  in  3  colour-RAM read data
- oAddr  out  15  RAM address {y[6:0], x[7:0]}
- oRamData  out  3  RAM write data
- oRamWren  out  1  RAM write enable
- oX  out  8  VGA x coordinate
- oY  out  7  VGA y coordinate
- oColour  out  3  VGA colour
- oPlot  out  1  VGA pixel write enable
- oBusy  out  1  high whenever state is not IDLE
- oFrameDone  out  1  one-cycle pulse at end of frame
- oOverrun  out  1  sticky: a tick arrived while busy

## Operation
- States: IDLE, CLEAR, RENDER, SCAN, DRAIN.
- IDLE: iFrameTick=1 moves to CLEAR next cycle (RENDER when the clear pass is compiled out). Counter x=y=0.
- Pixel counter: x increments every cycle of CLEAR/RENDER/SCAN; at x=H_PIXELS-1 it wraps to 0 and y increments. At (H_PIXELS-1, V_PIXELS-1), the counter returns to (0,0) and the state advances: CLEAR->RENDER->SCAN->DRAIN.
- oAddr = {y, x} in every state (0 in IDLE/DRAIN).
- CLEAR: oRamWren=1, oRamData=BG_COLOUR.
- RENDER: oRamWren=1, oRamData=iColour.
- SCAN: oRamWren=0; read address is oAddr. A RAM_LATENCY-deep shift register carries {valid, y, x}, so oPlot/oX/oY are its output and oColour=iRamQ.
- DRAIN: RAM_LATENCY cycles flushing the pipeline, then IDLE. oFrameDone=1 in the first IDLE cycle.
- iFrameTick while oBusy=1: ignored, and oOverrun is set on the next edge. It is cleared only by reset.
- Reset (async, any time, including mid-pass): state IDLE, counter 0, pipeline valid bits cleared. Every output is 0 (oAddr, oRamData, oRamWren, oX, oY, oColour, oPlot, oBusy, oFrameDone, oOverrun). The next frame starts only on a new tick after release.

## Timing
- N = H_PIXELS*V_PIXELS (19200 by default).
- Tick at cycle 0 in IDLE. The clear pass occupies cycles 1..N, render N+1..2N, scan 2N+1..3N, and DRAIN 3N+1..3N+RAM_LATENCY.
- oFrameDone pulses at cycle 3N+RAM_LATENCY+1. A tick in that same cycle is accepted, with oBusy=1 from the next cycle.
- oBusy is high for cycles 1..3N+RAM_LATENCY.
- Scan address issued at cycle c gives oPlot/oX/oY/oColour at cycle c+RAM_LATENCY. oPlot is high for exactly N cycles per frame.
- Without the clear pass, all intervals shift by N, so the frame takes 2N+RAM_LATENCY cycles.
- The frame fits a 60 Hz tick at 50 MHz (57.6k+1 << 833k cycles).

## Configuration
- FRAME_SEQ_CLEAR_EN defined: the CLEAR pass exists and runs before RENDER each frame.
- FRAME_SEQ_CLEAR_EN undefined: the CLEAR state is not compiled. IDLE goes directly to RENDER, and BG_COLOUR is unused.

## Test plan
All scenarios use H_PIXELS=8, V_PIXELS=4 (N=32), RAM_LATENCY=1, FRAME_SEQ_CLEAR_EN defined, and a behavioural RAM model.
- Reset then idle: hold iResetn=0 for 3 cycles, release, no tick -> all outputs 0 for 50 cycles.
- Single frame with iColour=x[2:0]: tick at cycle 0 -> 32 writes of 7 at cycles 1..32, 32 writes of x[2:0] at cycles 33..64. oPlot is high during cycles 66..97 with oColour=x[2:0], and oX/oY run (0,0)..(7,3) in order. oFrameDone pulses at cycle 98.
- Row wrap: during render, the address after {0,7} is {1,0}, and the address after {3,7} is {0,0} with the state in SCAN.
- Overrun: tick at cycle 0 and again at cycle 40 -> the second tick is ignored, oOverrun=1 from cycle 41, and no second frame runs.
- Back-to-back: tick at cycle 0 and at cycle 98 -> the second frame's first write is at cycle 99 and oOverrun stays 0.
- Reset mid-frame: iResetn low at cycle 50 -> outputs go to 0 immediately (asynchronous). After release, nothing happens until the next tick, which gives a full frame with correct timing.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Bus bundle between frame_sequencer and its neighbours: frame tick, scene colour,
// colour-RAM port and VGA plot port. The master side is the sequencer itself.
interface frame_sequencer_if;
    logic        iFrameTick;
    logic [2:0]  iColour;
    logic [2:0]  iRamQ;
    logic [14:0] oAddr;
    logic [2:0]  oRamData;
    logic        oRamWren;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [2:0]  oColour;
    logic        oPlot;
    logic        oBusy;
    logic        oFrameDone;
    logic        oOverrun;

    modport master (
        input  iFrameTick, iColour, iRamQ,
        output oAddr, oRamData, oRamWren, oX, oY, oColour, oPlot,
               oBusy, oFrameDone, oOverrun
    );

    modport slave (
        output iFrameTick, iColour, iRamQ,
        input  oAddr, oRamData, oRamWren, oX, oY, oColour, oPlot,
               oBusy, oFrameDone, oOverrun
    );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame clear / render / scan-out walker for the colour-RAM framebuffer.
// Define FRAME_SEQ_CLEAR_EN to include the background clear pass before render.
module frame_sequencer #(
    parameter int         H_PIXELS    = 160,
    parameter int         V_PIXELS    = 120,
    parameter logic [2:0] BG_COLOUR   = 3'd7,
    parameter int         RAM_LATENCY = 1
) (
    input logic              iClock,
    input logic              iResetn,
    frame_sequencer_if.master bus
);

`ifdef FRAME_SEQ_CLEAR_EN
    typedef enum logic [2:0] {IDLE, CLEAR, RENDER, SCAN, DRAIN} state_t;
    localparam state_t START_STATE = CLEAR;
`else
    typedef enum logic [2:0] {IDLE, RENDER, SCAN, DRAIN} state_t;
    localparam state_t START_STATE = RENDER;
`endif

    localparam logic [7:0] X_LAST     = 8'(H_PIXELS - 1);
    localparam logic [6:0] Y_LAST     = 7'(V_PIXELS - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RAM_LATENCY - 1);

    state_t state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [1:0] drain_q, drain_d;
    logic       wren_q, wren_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;

    logic [RAM_LATENCY-1:0]      pv_q, pv_d;
    logic [RAM_LATENCY-1:0][7:0] px_q, px_d;
    logic [RAM_LATENCY-1:0][6:0] py_q, py_d;

    logic last_x;
    logic last_pixel;
    logic scan_active;

    assign last_x      = (x_q == X_LAST);
    assign last_pixel  = last_x && (y_q == Y_LAST);
    assign scan_active = (state_q == SCAN);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (bus.iFrameTick & busy_q);

        case (state_q)
            IDLE: begin
                if (bus.iFrameTick) begin
                    state_d = START_STATE;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    drain_d = 2'd0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: begin
                if (last_x) begin
                    x_d = 8'd0;
                    y_d = (y_q == Y_LAST) ? 7'd0 : y_q + 7'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
                if (last_pixel) begin
                    drain_d = 2'd0;
                    if (state_q == SCAN) begin
                        state_d = DRAIN;
                    end else if (state_q == RENDER) begin
                        state_d = SCAN;
                    end else begin
                        state_d = RENDER;
                    end
                end
            end
        endcase

        wren_d = (state_d != IDLE) && (state_d != SCAN) && (state_d != DRAIN);
        busy_d = (state_d != IDLE);

        // Addresses issued during SCAN ride this pipe so x/y line up with the RAM read data.
        pv_d    = '0;
        px_d    = '0;
        py_d    = '0;
        pv_d[0] = scan_active;
        px_d[0] = scan_active ? x_q : 8'd0;
        py_d[0] = scan_active ? y_q : 7'd0;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            px_d[i] = px_q[i-1];
            py_d[i] = py_q[i-1];
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q   <= IDLE;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            drain_q   <= 2'd0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            pv_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            drain_q   <= drain_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            pv_q      <= pv_d;
            px_q      <= px_d;
            py_q      <= py_d;
        end
    end

    assign bus.oAddr      = {y_q, x_q};
    assign bus.oRamWren   = wren_q;
    assign bus.oRamData   = !wren_q ? 3'd0 : ((state_q == RENDER) ? bus.iColour : BG_COLOUR);
    assign bus.oPlot      = pv_q[RAM_LATENCY-1];
    assign bus.oX         = px_q[RAM_LATENCY-1];
    assign bus.oY         = py_q[RAM_LATENCY-1];
    assign bus.oColour    = pv_q[RAM_LATENCY-1] ? bus.iRamQ : 3'd0;
    assign bus.oBusy      = busy_q;
    assign bus.oFrameDone = done_q;
    assign bus.oOverrun   = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer on an 8x4 grid with a one-cycle colour-RAM model.
// Expected waveforms come from a cycle-indexed timing model of one frame.
module tb_frame_sequencer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int N   = H * V;
    localparam int LAT = 1;
`ifdef FRAME_SEQ_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int RS   = 1 + CLR * N;
    localparam int SS   = RS + N;
    localparam int PS   = SS + LAT;
    localparam int DONE = SS + N + LAT;

    logic iClock = 1'b0;
    logic iResetn;
    int   checks = 0;
    int   errors = 0;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .H_PIXELS(H),
        .V_PIXELS(V),
        .BG_COLOUR(3'd7),
        .RAM_LATENCY(LAT)
    ) dut (
        .iClock(iClock),
        .iResetn(iResetn),
        .bus(bus)
    );

    always #5 iClock = ~iClock;

    logic [2:0] mem [0:32767];
    logic [2:0] ram_q = 3'd0;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 3'd0;
    end

    always @(posedge iClock) begin
        if (bus.oRamWren) mem[bus.oAddr] <= bus.oRamData;
        ram_q <= mem[bus.oAddr];
    end

    assign bus.iRamQ   = ram_q;
    assign bus.iColour = bus.oAddr[2:0];

    logic [39:0] obs;
    assign obs = {bus.oAddr, bus.oRamData, bus.oRamWren, bus.oX, bus.oY,
                  bus.oColour, bus.oPlot, bus.oBusy, bus.oFrameDone};

    // Expected outputs c cycles after a tick accepted in IDLE; zero outside the frame.
    function automatic logic [39:0] exp_vec(int c);
        logic [14:0] a;
        logic [2:0]  d;
        logic        w;
        logic [7:0]  px;
        logic [6:0]  py;
        logic [2:0]  col;
        logic        p, b, dn;
        int          idx;
        a = '0; d = '0; w = 0; px = '0; py = '0; col = '0; p = 0; b = 0; dn = 0;
        if (c >= 1 && c < SS + N) begin
            idx = (c - 1) % N;
            a   = {7'(idx / H), 8'(idx % H)};
            if (CLR == 1 && c < RS) begin
                w = 1; d = 3'd7;
            end else if (c >= RS && c < SS) begin
                w = 1; d = 3'(idx % H);
            end
        end
        if (c >= PS && c < PS + N) begin
            idx = c - PS;
            p = 1; px = 8'(idx % H); py = 7'(idx / H); col = 3'(idx % H);
        end
        b  = (c >= 1 && c < DONE);
        dn = (c == DONE);
        return {a, d, w, px, py, col, p, b, dn};
    endfunction

    task automatic do_reset();
        iResetn = 1'b0;
        bus.iFrameTick = 1'b0;
        repeat (3) @(posedge iClock);
        #1 iResetn = 1'b1;
        @(posedge iClock);
        #1;
    endtask

    task automatic test_reset();
        iResetn = 1'b0;
        bus.iFrameTick = 1'b0;
        #1;
        checks++;
        if ({obs, bus.oOverrun} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL reset_assert got %h want 0", {obs, bus.oOverrun});
        end
        repeat (3) @(posedge iClock);
        #1 iResetn = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge iClock);
            #1;
            checks++;
            if ({obs, bus.oOverrun} !== 41'd0) begin
                errors++;
                $display("[TB] FAIL reset_idle c=%0d got %h want 0", c, {obs, bus.oOverrun});
            end
        end
    endtask

    task automatic test_single_frame();
        int plots = 0;
        do_reset();
        for (int c = 0; c <= DONE + 12; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0);
            checks++;
            if (obs !== exp_vec(c)) begin
                errors++;
                $display("[TB] FAIL single_frame c=%0d got %h want %h", c, obs, exp_vec(c));
            end
            if (bus.oPlot) plots++;
        end
        bus.iFrameTick = 1'b0;
        checks++;
        if (plots !== N) begin
            errors++;
            $display("[TB] FAIL plot_count got %0d want %0d", plots, N);
        end
        checks++;
        if (bus.oOverrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_overrun got %b want 0", bus.oOverrun);
        end
    endtask

    task automatic test_row_wrap();
        do_reset();
        for (int c = 0; c <= RS + 34; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0);
            if (c == RS + 7) begin
                checks++;
                if (bus.oAddr !== {7'd0, 8'd7}) begin
                    errors++;
                    $display("[TB] FAIL wrap_row0_end got %h want %h", bus.oAddr, {7'd0, 8'd7});
                end
            end
            if (c == RS + 8) begin
                checks++;
                if (bus.oAddr !== {7'd1, 8'd0} || bus.oRamWren !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wrap_row1_start got addr %h wren %b want %h wren 1",
                             bus.oAddr, bus.oRamWren, {7'd1, 8'd0});
                end
            end
            if (c == RS + 31) begin
                checks++;
                if (bus.oAddr !== {7'd3, 8'd7}) begin
                    errors++;
                    $display("[TB] FAIL wrap_last got %h want %h", bus.oAddr, {7'd3, 8'd7});
                end
            end
            if (c == RS + 32) begin
                checks++;
                if ({bus.oAddr, bus.oRamWren, bus.oBusy} !== {15'd0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL wrap_to_scan got addr %h wren %b busy %b want 0 0 1",
                             bus.oAddr, bus.oRamWren, bus.oBusy);
                end
            end
            if (c == RS + 33) begin
                checks++;
                if ({bus.oPlot, bus.oX, bus.oY} !== {1'b1, 8'd0, 7'd0}) begin
                    errors++;
                    $display("[TB] FAIL wrap_first_plot got plot %b x %0d y %0d want 1 0 0",
                             bus.oPlot, bus.oX, bus.oY);
                end
            end
        end
        bus.iFrameTick = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int c = 0; c <= DONE + 30; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0 || c == 40);
            checks++;
            if (obs !== exp_vec(c)) begin
                errors++;
                $display("[TB] FAIL overrun_frame c=%0d got %h want %h", c, obs, exp_vec(c));
            end
            checks++;
            if (bus.oOverrun !== (c >= 41)) begin
                errors++;
                $display("[TB] FAIL overrun_flag c=%0d got %b want %b", c, bus.oOverrun, (c >= 41));
            end
        end
        bus.iFrameTick = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c <= 2 * DONE + 4; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0 || c == DONE);
            checks++;
            if (obs !== (exp_vec(c) | exp_vec(c - DONE))) begin
                errors++;
                $display("[TB] FAIL back_to_back c=%0d got %h want %h", c, obs,
                         exp_vec(c) | exp_vec(c - DONE));
            end
            checks++;
            if (bus.oOverrun !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_overrun c=%0d got %b want 0", c, bus.oOverrun);
            end
        end
        bus.iFrameTick = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0);
        end
        checks++;
        if (bus.oBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy_before got %b want 1", bus.oBusy);
        end
        iResetn = 1'b0;
        #1;
        checks++;
        if ({obs, bus.oOverrun} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset got %h want 0", {obs, bus.oOverrun});
        end
        repeat (3) @(posedge iClock);
        #1 iResetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge iClock);
            #1;
            checks++;
            if ({obs, bus.oOverrun} !== 41'd0) begin
                errors++;
                $display("[TB] FAIL mid_post_idle c=%0d got %h want 0", c, {obs, bus.oOverrun});
            end
        end
        for (int c = 0; c <= DONE + 2; c++) begin
            if (c > 0) begin @(posedge iClock); #1; end
            bus.iFrameTick = (c == 0);
            checks++;
            if (obs !== exp_vec(c)) begin
                errors++;
                $display("[TB] FAIL mid_next_frame c=%0d got %h want %h", c, obs, exp_vec(c));
            end
        end
        bus.iFrameTick = 1'b0;
    endtask

    initial begin
        bus.iFrameTick = 1'b0;
        test_reset();
        test_single_frame();
        test_row_wrap();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
